// File: rtl/trackball_quad.sv
// Trackball/spinner motion accumulator: per-axis signed deltas arrive on a toggle
// event, then drain one count per prescaler tick as direction/toggle or Gray quadrature.
module trackball_quad #(
    parameter int AXES     = 2,
    parameter int ACC_W    = 12,
    parameter int STEP_DIV = 16
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                evt_toggle_i,
    input  logic [9*AXES-1:0]   delta_i,
    input  logic                flip_i,
    input  logic [1:0]          gain_i,
    input  logic                mode_i,
    output logic [2*AXES-1:0]   trak_o,
    output logic [AXES-1:0]     busy_o
);

    // The running sum is kept a few bits wider than the accumulator so that a full-scale
    // delta added onto a saturated accumulator cannot wrap before it is clamped.
    localparam int SW = ACC_W + 5;
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]        PS_MAX = PW'(STEP_DIV - 1);
    localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO = SW'(-(1 << (ACC_W - 1)));

    logic          prev_evt;
    logic          evt;
    logic [PW-1:0] ps_cnt;
    logic          tick;

    assign evt  = evt_toggle_i ^ prev_evt;
    assign tick = (ps_cnt == PS_MAX);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            prev_evt <= 1'b0;
            ps_cnt   <= '0;
        end else begin
            prev_evt <= evt_toggle_i;
            ps_cnt   <= tick ? '0 : ps_cnt + 1'b1;
        end
    end

    for (genvar n = 0; n < AXES; n++) begin : g_axis
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] acc_next;
        logic signed [SW-1:0]    ext;
        logic signed [SW-1:0]    sum;
        logic                    step_up;
        logic                    step_dn;
        logic [1:0]              phase;
        logic                    dir;
        logic [1:0]              trak_q;

        always_comb begin
            ext = {{(SW-9){delta_i[9*n+8]}}, delta_i[9*n +: 9]};
            if (flip_i) ext = -ext;
            ext = ext <<< gain_i;

            // Step direction comes from the accumulator before this cycle's update.
            step_up = tick && !acc[ACC_W-1] && (acc != '0);
            step_dn = tick && acc[ACC_W-1];

            sum = SW'(acc) + (evt ? ext : SW'(0));
            if (step_up) sum = sum - SW'(1);
            if (step_dn) sum = sum + SW'(1);

            if (sum > SAT_HI)      acc_next = SAT_HI[ACC_W-1:0];
            else if (sum < SAT_LO) acc_next = SAT_LO[ACC_W-1:0];
            else                   acc_next = sum[ACC_W-1:0];
        end

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                acc    <= '0;
                phase  <= 2'b00;
                dir    <= 1'b0;
                trak_q <= 2'b00;
            end else begin
                acc <= acc_next;
                if (step_up) begin
                    phase <= phase + 2'd1;
                    dir   <= 1'b1;
                end else if (step_dn) begin
                    phase <= phase - 2'd1;
                    dir   <= 1'b0;
                end
                // Mapping uses the phase held before this edge, so outputs lag a step by one cycle.
                trak_q <= mode_i ? {phase[1], phase[1] ^ phase[0]} : {dir, phase[0]};
            end
        end

        assign trak_o[2*n +: 2] = trak_q;
        assign busy_o[n]        = (acc != '0);
    end

endmodule

// File: tb/tb_trackball_quad.sv
// Directed bench for trackball_quad: expected output pairs are queued per axis when
// motion is injected and consumed whenever the DUT's output pair changes.
module tb_trackball_quad;

    localparam int AXES     = 2;
    localparam int ACC_W    = 10;
    localparam int STEP_DIV = 4;

    logic        clk_sys      = 1'b0;
    logic        reset        = 1'b1;
    logic        evt_toggle_i = 1'b0;
    logic [17:0] delta_i      = '0;
    logic        flip_i       = 1'b0;
    logic [1:0]  gain_i       = 2'd0;
    logic        mode_i       = 1'b0;
    logic [3:0]  trak_o;
    logic [1:0]  busy_o;

    int compared   = 0;
    int mismatched = 0;
    int next_edge  = 0;
    int changes0   = 0;
    int changes1   = 0;
    logic [1:0] last0 = 2'b00;
    logic [1:0] last1 = 2'b00;
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    trackball_quad #(
        .AXES(AXES),
        .ACC_W(ACC_W),
        .STEP_DIV(STEP_DIV)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .evt_toggle_i(evt_toggle_i),
        .delta_i(delta_i),
        .flip_i(flip_i),
        .gain_i(gain_i),
        .mode_i(mode_i),
        .trak_o(trak_o),
        .busy_o(busy_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic toggle, input logic [17:0] delta);
        delta_i = delta;
        if (toggle) evt_toggle_i = ~evt_toggle_i;
    endtask

    // Ends on the negedge that releases reset, so the next rising edge is edge 1.
    task automatic do_reset(input logic evt_level);
        @(posedge clk_sys);
        #2;
        reset        = 1'b1;
        evt_toggle_i = evt_level;
        delta_i      = '0;
        changes0     = 0;
        changes1     = 0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset     = 1'b0;
        next_edge = 1;
    endtask

    // Returns at the falling edge just before rising edge k (i.e. just after edge k-1).
    task automatic advance_to(input int k);
        while (next_edge < k) begin
            @(negedge clk_sys);
            next_edge++;
        end
    endtask

    always @(negedge clk_sys) begin
        if (reset) begin
            last0 = 2'b00;
            last1 = 2'b00;
        end else begin
            if (trak_o[1:0] !== last0) begin
                changes0++;
                checkOutput("ax0_queued", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) checkOutput("ax0_pair", 32'(trak_o[1:0]), 32'(q0.pop_front()));
                last0 = trak_o[1:0];
            end
            if (trak_o[3:2] !== last1) begin
                changes1++;
                checkOutput("ax1_queued", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) checkOutput("ax1_pair", 32'(trak_o[3:2]), 32'(q1.pop_front()));
                last1 = trak_o[3:2];
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3;
        checkOutput("reset_trak", 32'(trak_o), 32'd0);
        checkOutput("reset_busy", 32'(busy_o), 32'd0);

        // +3 on axis 0, direction/toggle output
        do_reset(1'b0);
        q0.push_back(2'b11); q0.push_back(2'b10); q0.push_back(2'b11);
        applyStimulus(1'b1, {9'd0, 9'd3});
        advance_to(2);  checkOutput("t1_busy_start", 32'(busy_o), 32'd1);
        advance_to(5);  checkOutput("t1_before_step", 32'(trak_o[1:0]), 32'd0);
        advance_to(6);  checkOutput("t1_step1", 32'(trak_o[1:0]), 32'd3);
        advance_to(9);  checkOutput("t1_spacing", 32'(trak_o[1:0]), 32'd3);
        advance_to(10); checkOutput("t1_step2", 32'(trak_o[1:0]), 32'd2);
        advance_to(12); checkOutput("t1_busy_last", 32'(busy_o), 32'd1);
        advance_to(13); checkOutput("t1_busy_fall", 32'(busy_o), 32'd0);
        advance_to(14); checkOutput("t1_step3", 32'(trak_o[1:0]), 32'd3);
        advance_to(40);
        checkOutput("t1_drained", 32'(q0.size()), 32'd0);
        checkOutput("t1_steps", 32'(changes0), 32'd3);

        // -2 on axis 1, Gray output, then the same delta flipped
        do_reset(1'b0);
        mode_i = 1'b1;
        q1.push_back(2'b10); q1.push_back(2'b11);
        applyStimulus(1'b1, {9'h1FE, 9'd0});
        advance_to(20);
        checkOutput("t2_drained", 32'(q1.size()), 32'd0);
        checkOutput("t2_steps", 32'(changes1), 32'd2);
        checkOutput("t2_ax0_idle", 32'(trak_o[1:0]), 32'd0);
        checkOutput("t2_busy", 32'(busy_o), 32'd0);
        do_reset(1'b0);
        flip_i = 1'b1;
        q1.push_back(2'b01); q1.push_back(2'b11);
        applyStimulus(1'b1, {9'h1FE, 9'd0});
        advance_to(20);
        checkOutput("t2f_drained", 32'(q1.size()), 32'd0);
        checkOutput("t2f_steps", 32'(changes1), 32'd2);
        flip_i = 1'b0;
        mode_i = 1'b0;

        // Saturation: ten x8 events of +255 on axis 0 alongside -1 on axis 1
        do_reset(1'b0);
        gain_i = 2'd3;
        for (int k = 1; k <= 513; k++) q0.push_back({1'b1, k[0]});
        for (int k = 1; k <= 80; k++)  q1.push_back({1'b0, k[0]});
        for (int i = 1; i <= 10; i++) begin
            advance_to(i);
            applyStimulus(1'b1, {9'h1FF, 9'd255});
        end
        advance_to(12);   checkOutput("t3_busy_both", 32'(busy_o), 32'd3);
        advance_to(1000); checkOutput("t3_busy_ax0_only", 32'(busy_o), 32'd1);
        advance_to(2100);
        checkOutput("t3_ax0_drained", 32'(q0.size()), 32'd0);
        checkOutput("t3_ax1_drained", 32'(q1.size()), 32'd0);
        checkOutput("t3_ax0_steps", 32'(changes0), 32'd513);
        checkOutput("t3_ax1_steps", 32'(changes1), 32'd80);
        checkOutput("t3_final_trak", 32'(trak_o), 32'h3);
        checkOutput("t3_idle", 32'(busy_o), 32'd0);
        gain_i = 2'd0;

        // Event at reset release, then an event landing on a tick with acc = +1
        do_reset(1'b1);
        applyStimulus(1'b0, {9'd0, 9'd1});
        q0.push_back(2'b11); q0.push_back(2'b10);
        advance_to(2);  checkOutput("t4_release_event", 32'(busy_o), 32'd1);
        advance_to(4);  applyStimulus(1'b1, {9'd0, 9'd1});
        advance_to(5);
        checkOutput("t4_busy_hold", 32'(busy_o), 32'd1);
        checkOutput("t4_trak_lag", 32'(trak_o[1:0]), 32'd0);
        advance_to(6);  checkOutput("t4_step1", 32'(trak_o[1:0]), 32'd3);
        advance_to(9);  checkOutput("t4_busy_end", 32'(busy_o), 32'd0);
        advance_to(10); checkOutput("t4_step2", 32'(trak_o[1:0]), 32'd2);
        advance_to(30);
        checkOutput("t4_steps", 32'(changes0), 32'd2);
        checkOutput("t4_drained", 32'(q0.size()), 32'd0);

        // Reset asserted between edges while +20 is still draining
        do_reset(1'b0);
        q0.push_back(2'b11); q0.push_back(2'b10);
        applyStimulus(1'b1, {9'd0, 9'd20});
        advance_to(10);
        checkOutput("t5_mid_trak", 32'(trak_o[1:0]), 32'd2);
        checkOutput("t5_mid_busy", 32'(busy_o), 32'd1);
        #2;
        reset        = 1'b1;
        evt_toggle_i = 1'b0;
        #1;
        checkOutput("t5_async_trak", 32'(trak_o), 32'd0);
        checkOutput("t5_async_busy", 32'(busy_o), 32'd0);
        changes0 = 0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset     = 1'b0;
        next_edge = 1;
        advance_to(100);
        checkOutput("t5_no_resume", 32'(changes0), 32'd0);
        checkOutput("t5_busy_after", 32'(busy_o), 32'd0);
        checkOutput("t5_drained", 32'(q0.size()), 32'd0);

        // Mode switched mid-motion: +6 steps, mapping changes one cycle after mode_i
        do_reset(1'b0);
        q0.push_back(2'b11); q0.push_back(2'b10); q0.push_back(2'b11);
        q0.push_back(2'b10); q0.push_back(2'b00); q0.push_back(2'b01); q0.push_back(2'b11);
        applyStimulus(1'b1, {9'd0, 9'd6});
        advance_to(11);
        checkOutput("t6_before_mode", 32'(trak_o[1:0]), 32'd2);
        mode_i = 1'b1;
        advance_to(12);
        checkOutput("t6_after_mode", 32'(trak_o[1:0]), 32'd3);
        advance_to(40);
        checkOutput("t6_changes", 32'(changes0), 32'd7);
        checkOutput("t6_drained", 32'(q0.size()), 32'd0);
        checkOutput("t6_busy", 32'(busy_o), 32'd0);
        mode_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
